// File: rtl/ldpc_pkg.sv
// Shared LDPC datapath types: LLR width and limits, variable-node FSM states,
// and the symmetric saturation used on every LLR input and arithmetic result.
package ldpc_pkg;

  localparam int LLR_W = 32;
  localparam logic signed [LLR_W-1:0] LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};
  localparam logic signed [LLR_W-1:0] LLR_MIN = -LLR_MAX;

  typedef enum logic [1:0] {IDLE, COLLECT, SUM, EMIT} vnu_state_e;

  // Saturates a sign-extended (LLR_W+2)-bit value to +/-LLR_MAX; this also maps -2^(LLR_W-1) to LLR_MIN.
  function automatic logic signed [LLR_W-1:0] llr_sat(input logic signed [LLR_W+1:0] x);
    logic signed [LLR_W+1:0] max_x;
    logic signed [LLR_W+1:0] min_x;
    max_x = {3'b000, {(LLR_W-1){1'b1}}};
    min_x = -max_x;
    if (x > max_x) return LLR_MAX;
    if (x < min_x) return LLR_MIN;
    return x[LLR_W-1:0];
  endfunction

endpackage

// File: rtl/llr_sat_addsub.sv
// Combinational saturating add (sub=0) or subtract (sub=1) of two signed LLRs.
// Zero latency; no flow control.
module llr_sat_addsub
  import ldpc_pkg::*;
#(
  parameter int W = LLR_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  logic signed [W+1:0] a_x;
  logic signed [W+1:0] b_x;
  logic signed [W+1:0] s_x;

  always_comb begin
    a_x = {{2{a[W-1]}}, a};
    b_x = {{2{b[W-1]}}, b};
    s_x = sub ? (a_x - b_x) : (a_x + b_x);
    y   = llr_sat(s_x);
  end

endmodule

// File: rtl/vnu_serial.sv
// Serial variable node: channel LLR + DV R messages in, posterior/hard bit and DV extrinsic Q out.
// First Q two edges after last R; inputs ready only in their phase; Q held stable until q_ready.
module vnu_serial
  import ldpc_pkg::*;
#(
  parameter int W  = LLR_W,
  parameter int DV = 3,
  parameter int IW = $clog2(DV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ch_valid,
  output logic          ch_ready,
  input  logic [W-1:0]  ch_llr,
  input  logic          r_valid,
  output logic          r_ready,
  input  logic [W-1:0]  r_msg,
  output logic          q_valid,
  input  logic          q_ready,
  output logic [W-1:0]  q_msg,
  output logic [IW-1:0] q_idx,
  output logic          q_last,
  output logic [W-1:0]  post_llr,
  output logic          hard_bit
);

  localparam logic [IW-1:0] LAST = IW'(DV - 1);

  vnu_state_e    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  rmem_q [DV];
  logic [W-1:0]  rmem_d [DV];
  logic [W-1:0]  post_q, post_d;
  logic          hard_q, hard_d;
  logic [W-1:0]  qmsg_q, qmsg_d;
  logic [IW-1:0] qidx_q, qidx_d;
  logic          qlast_q, qlast_d;

  logic [W-1:0]  ch_clamp, r_clamp, acc_sum, ext_a, ext_b, ext_y;
  logic [IW-1:0] nxt_idx;

  assign ch_clamp = llr_sat({{2{ch_llr[W-1]}}, ch_llr});
  assign r_clamp  = llr_sat({{2{r_msg[W-1]}}, r_msg});
  assign nxt_idx  = (cnt_q == LAST) ? '0 : cnt_q + IW'(1);

  // SUM forms Q0 from the fresh accumulator; EMIT walks the stored R values against the held posterior.
  assign ext_a = (state_q == SUM) ? acc_q : post_q;
  assign ext_b = (state_q == SUM) ? rmem_q[0] : rmem_q[nxt_idx];

  llr_sat_addsub #(.W(W)) u_acc (.a(acc_q), .b(r_clamp), .sub(1'b0), .y(acc_sum));
  llr_sat_addsub #(.W(W)) u_ext (.a(ext_a), .b(ext_b), .sub(1'b1), .y(ext_y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rmem_q  <= '{default: '0};
      post_q  <= '0;
      hard_q  <= 1'b0;
      qmsg_q  <= '0;
      qidx_q  <= '0;
      qlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rmem_q  <= rmem_d;
      post_q  <= post_d;
      hard_q  <= hard_d;
      qmsg_q  <= qmsg_d;
      qidx_q  <= qidx_d;
      qlast_q <= qlast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ch_valid) state_d = COLLECT;
      COLLECT: if (r_valid && cnt_q == LAST) state_d = SUM;
      SUM:     state_d = EMIT;
      EMIT:    if (q_ready && qlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rmem_d  = rmem_q;
    post_d  = post_q;
    hard_d  = hard_q;
    qmsg_d  = qmsg_q;
    qidx_d  = qidx_q;
    qlast_d = qlast_q;
    case (state_q)
      IDLE: begin
        if (ch_valid) begin
          acc_d = ch_clamp;
          cnt_d = '0;
        end
      end
      COLLECT: begin
        if (r_valid) begin
          rmem_d[cnt_q] = r_clamp;
          acc_d         = acc_sum;
          cnt_d         = cnt_q + IW'(1);
        end
      end
      SUM: begin
        post_d  = acc_q;
        hard_d  = acc_q[W-1];
        qmsg_d  = ext_y;
        qidx_d  = '0;
        qlast_d = (LAST == '0);
        cnt_d   = '0;
      end
      EMIT: begin
        if (q_ready && !qlast_q) begin
          cnt_d   = nxt_idx;
          qmsg_d  = ext_y;
          qidx_d  = nxt_idx;
          qlast_d = (nxt_idx == LAST);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ch_ready = !rst && (state_q == IDLE);
    r_ready  = !rst && (state_q == COLLECT);
    q_valid  = (state_q == EMIT);
    q_msg    = qmsg_q;
    q_idx    = qidx_q;
    q_last   = qlast_q;
    post_llr = post_q;
    hard_bit = hard_q;
  end

endmodule

// File: tb/tb_vnu_serial.sv
// Self-checking bench for vnu_serial: directed frames plus randomized frames
// compared against an integer-arithmetic model of the posterior/extrinsic rules.
module tb_vnu_serial;

  localparam int W  = 32;
  localparam int DV = 3;
  localparam int IW = 2;
  localparam longint MAXV = 64'sd2147483647;

  logic          clk = 1'b0;
  logic          rst;
  logic          ch_valid, ch_ready;
  logic [W-1:0]  ch_llr;
  logic          r_valid, r_ready;
  logic [W-1:0]  r_msg;
  logic          q_valid, q_ready;
  logic [W-1:0]  q_msg;
  logic [IW-1:0] q_idx;
  logic          q_last;
  logic [W-1:0]  post_llr;
  logic          hard_bit;

  int n_tests = 0;
  int n_fail  = 0;
  bit busy_chk = 1'b0;

  vnu_serial #(.W(W), .DV(DV), .IW(IW)) dut (
    .clk(clk), .rst(rst),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_llr(ch_llr),
    .r_valid(r_valid), .r_ready(r_ready), .r_msg(r_msg),
    .q_valid(q_valid), .q_ready(q_ready), .q_msg(q_msg),
    .q_idx(q_idx), .q_last(q_last),
    .post_llr(post_llr), .hard_bit(hard_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > MAXV) return MAXV;
    if (x < -MAXV) return -MAXV;
    return x;
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic logic [31:0] rnd_llr();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0001;
      3: return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom();
    endcase
  endfunction

  task automatic send_ch(input logic [31:0] v, input bit hold, input logic [31:0] next_ch);
    int t = 0;
    ch_valid = 1'b1;
    ch_llr   = v;
    while (!ch_ready && t < 100) begin @(negedge clk); t++; end
    check("ch_ready_to", ch_ready, 1);
    @(negedge clk);
    if (hold) ch_llr = next_ch;
    else ch_valid = 1'b0;
    check("ch_ready_busy", ch_ready, 0);
  endtask

  task automatic send_r(input logic [31:0] v, input int gap);
    int t = 0;
    r_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      r_msg = $urandom();
      @(negedge clk);
      if (busy_chk) check("ch_busy", ch_ready, 0);
    end
    r_valid = 1'b1;
    r_msg   = v;
    while (!r_ready && t < 100) begin @(negedge clk); t++; end
    check("r_ready_to", r_ready, 1);
    if (busy_chk) check("ch_busy", ch_ready, 0);
    @(negedge clk);
    r_valid = 1'b0;
  endtask

  task automatic recv_q(input logic [31:0] em, input int ei, input bit el, input int stall);
    int t = 0;
    q_ready = 1'b0;
    while (!q_valid && t < 100) begin @(negedge clk); t++; end
    check("q_valid_to", q_valid, 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_vld", q_valid, 1);
      check("stall_msg", q_msg, em);
      check("stall_idx", q_idx, ei);
    end
    check("q_msg", q_msg, em);
    check("q_idx", q_idx, ei);
    check("q_last", q_last, el);
    if (busy_chk) check("ch_busy", ch_ready, 0);
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] ch, input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input int gap, input int stall,
                           input bit hold, input logic [31:0] next_ch);
    longint acc;
    logic [31:0] rv [3];
    logic [31:0] qexp [3];
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    acc = sat(sx(ch));
    for (int i = 0; i < DV; i++) acc = sat(acc + sat(sx(rv[i])));
    for (int i = 0; i < DV; i++) qexp[i] = 32'(sat(acc - sat(sx(rv[i]))));
    send_ch(ch, hold, next_ch);
    busy_chk = hold;
    for (int i = 0; i < DV; i++) send_r(rv[i], gap);
    check("sum_no_valid", q_valid, 0);
    @(negedge clk);
    check("q_latency", q_valid, 1);
    for (int i = 0; i < DV; i++) recv_q(qexp[i], i, (i == DV - 1), stall);
    busy_chk = 1'b0;
    check("post_llr", post_llr, 32'(acc));
    check("hard_bit", hard_bit, (acc < 0));
    check("ch_ready_after", ch_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ch_valid = 1'b0; ch_llr = '0;
    r_valid = 1'b0; r_msg = '0;
    q_ready = 1'b0;
    #1;
    check("rst_q_valid", q_valid, 0);
    check("rst_q_msg", q_msg, 0);
    check("rst_q_idx", q_idx, 0);
    check("rst_q_last", q_last, 0);
    check("rst_post", post_llr, 0);
    check("rst_hard", hard_bit, 0);
    check("rst_ch_ready", ch_ready, 0);
    check("rst_r_ready", r_ready, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("ch_ready_init", ch_ready, 1);
    @(negedge clk);

    // Directed frames
    run_frame(32'd10, 32'd3, -32'sd5, 32'd7, 0, 0, 1'b0, 32'd0);
    check("s1_post", post_llr, 32'd15);
    run_frame(-32'sd20, 32'd4, 32'd4, 32'd4, 0, 0, 1'b0, 32'd0);
    check("s2_post", post_llr, -32'sd8);
    check("s2_hard", hard_bit, 1);
    run_frame(32'h7FFF_FFF0, 32'h100, 32'h100, 32'd0, 0, 0, 1'b0, 32'd0);
    check("s3a_post", post_llr, 32'h7FFF_FFFF);
    run_frame(32'h8000_0000, 32'd0, 32'd0, 32'd0, 0, 0, 1'b0, 32'd0);
    check("s3b_post", post_llr, 32'h8000_0001);
    run_frame(32'd10, 32'd3, -32'sd5, 32'd7, 2, 5, 1'b0, 32'd0);
    check("s4_post", post_llr, 32'd15);
    run_frame(32'd5, -32'sd5, 32'd0, 32'd0, 0, 0, 1'b0, 32'd0);
    check("zero_hard", hard_bit, 0);

    // Reset mid-frame after two R handshakes
    send_ch(32'd100, 1'b0, 32'd0);
    send_r(32'd50, 0);
    send_r(32'd60, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_q_valid", q_valid, 0);
    check("mid_rst_q_msg", q_msg, 0);
    check("mid_rst_q_idx", q_idx, 0);
    check("mid_rst_q_last", q_last, 0);
    check("mid_rst_post", post_llr, 0);
    check("mid_rst_hard", hard_bit, 0);
    check("mid_rst_ch_ready", ch_ready, 0);
    check("mid_rst_r_ready", r_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ch_ready_release", ch_ready, 1);
    run_frame(32'd10, 32'd3, -32'sd5, 32'd7, 0, 0, 1'b0, 32'd0);
    check("s5_post", post_llr, 32'd15);

    // Back-to-back with ch_valid held high
    run_frame(32'd10, 32'd3, -32'sd5, 32'd7, 0, 0, 1'b1, -32'sd100);
    run_frame(-32'sd100, 32'd1, 32'd2, 32'd3, 0, 0, 1'b0, 32'd0);
    check("s6_post", post_llr, -32'sd94);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      run_frame(rnd_llr(), rnd_llr(), rnd_llr(), rnd_llr(),
                $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
